filter_controller: RTL and testbench
====================================

// Module: filter_controller
// PURPOSE
//  Main FSM sequencing the image-filtering datapath: filter load, image window load, 16-tap MAC
//  per output pixel, 4-result packing in the shift register, memory write-back and row sliding.
//  Drives every sel/wr/shift/rstN/enN/enable-vector/base-address input of the datapath and
//  consumes its coutN flags. Single start/done handshake to the top level.
// PARAMETERS
//  IMG_BASE     7'd0    X base: first image word address
//  FLT_BASE     7'd64   Y base: first filter word address
//  OUT_BASE     7'd80   Z base: first result word address
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   sampled in IDLE only; launches one full filtering pass
//  done         out  1   high in DONE state; held until start is seen low
//  cout3,cout5,cout6,cout7,cout8,cout9,cout11  in  1 each  datapath counter terminal flags
//  sel          out  2   address mux: 00=X path, 01=Y path, 10=Z path
//  wr           out  1   memory write strobe
//  shift        out  1   image buffer row shift
//  rst3,rst5,rst6,rst7,rst8,rst9,rst11,rst12  out 1 each  synchronous clears of datapath counters/MAC
//  en3,en5,en6,en7,en8,en9,en10,en11,en12     out 1 each  datapath counter/MAC/shift-reg enables
//  en1,en2,en4  out  16  filter buffer / image buffer / window buffer load enables
//  X,Y,Z        out  7   base addresses (constant = IMG_BASE, FLT_BASE, OUT_BASE)
// BEHAVIOUR
//  - Reset (async): state=IDLE; all outputs 0 except X/Y/Z = parameters; internal k/c = 0.
//  - Moore outputs; any output not listed for a state is 0. Memory read is combinational.
//  - IDLE:    done=0. start=1 -> INIT.
//  - INIT:    1 cycle; rst3,rst5,rst6,rst7,rst8,rst9,rst11,rst12 = 1 -> LD_FLT.
//  - LD_FLT:  sel=01, en9=1, en1[4k+3:4k]=4'hF (k = internal 2-bit count, +1 per cycle).
//             cout9=1 -> LD_IMG (4 cycles total).
//  - LD_IMG:  sel=00, en6=1, en2=one-hot(c), c = internal 4-bit count, +1 per cycle.
//             c==15 -> WIN (16 cycles total); c wraps to 0.
//  - WIN:     1 cycle; en4=16'hFFFF, rst5=1, rst12=1 -> MAC.
//  - MAC:     en5=1, en12=1. cout5=1 -> PUSH (16 MAC cycles).
//  - PUSH:    1 cycle; en10=1, en8=1, en3=1.
//             cout8=1 -> WRITE; else cout3=1 -> ROW; else -> WIN.
//  - WRITE:   1 cycle; sel=10, wr=1, en7=1. cout7=1 -> DONE; else cout3=1 -> ROW; else -> WIN.
//  - ROW:     1 cycle; shift=1, sel=00, en6=1, en2=16'hF000, rst3=1 -> WIN.
//  - DONE:    done=1; start=0 -> IDLE (start held high keeps DONE; no auto-restart).
//  - en11 permanently 0; rst11 only in INIT.
//  - Simultaneous flags: priority cout7 > cout8 > cout3 as ordered above.
//  - start in non-IDLE states ignored. Async rst mid-pass aborts immediately to IDLE;
//    datapath state is not trusted after abort (next pass re-clears via INIT).
//  - Output-pixel latency: WIN+16 MAC+PUSH = 18 cycles; write every 4th pixel (+1 cycle).
// TESTING
//  1. rst=1 for 2 cycles, start=0 -> all outputs 0, X=0,Y=64,Z=80, done=0, state IDLE.
//  2. start pulse -> INIT 1 cycle (all rstN=1), then en1 = 000F,00F0,0F00,F000 with sel=01,
//     cout9 on 4th -> next cycle sel=00, en2=0001.
//  3. LD_IMG: en2 walks 0001..8000 over 16 cycles, then en4=FFFF for 1 cycle, then
//     en5=en12=1 exactly 16 cycles until cout5.
//  4. Model cout8 on 4th PUSH -> next cycle sel=10, wr=1, en7=1 for exactly 1 cycle.
//  5. cout3 and cout8 same PUSH -> WRITE then ROW (shift=1, en2=F000, rst3=1); cout7 in
//     WRITE -> done=1 held while start=1, IDLE one cycle after start=0.
//  6. Assert rst during MAC -> outputs clear asynchronously; new start replays INIT.

Source files
------------

// File: rtl/filter_controller_if.sv
// filter_controller_if: start/done handshake plus every control and flag line between the
// filter controller and the image-filtering datapath.
interface filter_controller_if;
    logic        start, done;
    logic        cout3, cout5, cout6, cout7, cout8, cout9, cout11;
    logic [1:0]  sel;
    logic        wr, shift;
    logic        rst3, rst5, rst6, rst7, rst8, rst9, rst11, rst12;
    logic        en3, en5, en6, en7, en8, en9, en10, en11, en12;
    logic [15:0] en1, en2, en4;
    logic [6:0]  X, Y, Z;
    modport master (
        input  start, cout3, cout5, cout6, cout7, cout8, cout9, cout11,
        output done, sel, wr, shift,
               rst3, rst5, rst6, rst7, rst8, rst9, rst11, rst12,
               en3, en5, en6, en7, en8, en9, en10, en11, en12,
               en1, en2, en4, X, Y, Z
    );
    modport slave (
        output start, cout3, cout5, cout6, cout7, cout8, cout9, cout11,
        input  done, sel, wr, shift,
               rst3, rst5, rst6, rst7, rst8, rst9, rst11, rst12,
               en3, en5, en6, en7, en8, en9, en10, en11, en12,
               en1, en2, en4, X, Y, Z
    );
endinterface

// File: rtl/filter_controller.sv
// filter_controller: Moore FSM sequencing filter load, window load, 16-tap MAC, result
// packing, write-back and row sliding of the image-filtering datapath.
module filter_controller #(
    parameter logic [6:0] IMG_BASE = 7'd0,
    parameter logic [6:0] FLT_BASE = 7'd64,
    parameter logic [6:0] OUT_BASE = 7'd80
) (
    input logic clk,
    input logic rst,
    filter_controller_if.master bus
);
    typedef enum logic [3:0] {IDLE, INIT, LD_FLT, LD_IMG, WIN, MAC, PUSH, WRITE, ROW, DONE} state_t;
    state_t state, next;
    logic [1:0] k;
    logic [3:0] c;

    assign bus.X = IMG_BASE;
    assign bus.Y = FLT_BASE;
    assign bus.Z = OUT_BASE;

    // k/c are also cleared in INIT so an aborted pass cannot leave them misaligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            c     <= '0;
        end else begin
            state <= next;
            k     <= state == INIT ? 2'd0 : state == LD_FLT ? k + 2'd1 : k;
            c     <= state == INIT ? 4'd0 : state == LD_IMG ? c + 4'd1 : c;
        end
    end

    always_comb begin
        next      = state;
        bus.done  = 1'b0;
        bus.sel   = 2'b00;
        bus.wr    = 1'b0;
        bus.shift = 1'b0;
        {bus.rst3, bus.rst5, bus.rst6, bus.rst7, bus.rst8, bus.rst9, bus.rst11, bus.rst12} = '0;
        {bus.en3, bus.en5, bus.en6, bus.en7, bus.en8, bus.en9, bus.en10, bus.en11, bus.en12} = '0;
        bus.en1   = '0;
        bus.en2   = '0;
        bus.en4   = '0;
        case (state)
            IDLE:   next = bus.start ? INIT : IDLE;
            INIT: begin
                {bus.rst3, bus.rst5, bus.rst6, bus.rst7, bus.rst8, bus.rst9, bus.rst11, bus.rst12} = '1;
                next = LD_FLT;
            end
            LD_FLT: begin
                bus.sel = 2'b01;
                bus.en9 = 1'b1;
                bus.en1 = 16'hF << {k, 2'b00};
                next    = bus.cout9 ? LD_IMG : LD_FLT;
            end
            LD_IMG: begin
                bus.en6 = 1'b1;
                bus.en2 = 16'd1 << c;
                next    = c == 4'd15 ? WIN : LD_IMG;
            end
            WIN: begin
                bus.en4   = 16'hFFFF;
                bus.rst5  = 1'b1;
                bus.rst12 = 1'b1;
                next      = MAC;
            end
            MAC: begin
                bus.en5  = 1'b1;
                bus.en12 = 1'b1;
                next     = bus.cout5 ? PUSH : MAC;
            end
            PUSH: begin
                bus.en10 = 1'b1;
                bus.en8  = 1'b1;
                bus.en3  = 1'b1;
                next     = bus.cout8 ? WRITE : bus.cout3 ? ROW : WIN;
            end
            WRITE: begin
                bus.sel = 2'b10;
                bus.wr  = 1'b1;
                bus.en7 = 1'b1;
                next    = bus.cout7 ? DONE : bus.cout3 ? ROW : WIN;
            end
            ROW: begin
                bus.shift = 1'b1;
                bus.en6   = 1'b1;
                bus.en2   = 16'hF000;
                bus.rst3  = 1'b1;
                next      = WIN;
            end
            DONE: begin
                bus.done = 1'b1;
                next     = bus.start ? DONE : IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_filter_controller.sv
// tb_filter_controller: vector table with scoreboard for the filter controller, plus an
// asynchronous-abort sequence.
module tb_filter_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    filter_controller_if f();
    filter_controller dut (.clk(clk), .rst(rst), .bus(f));

    typedef struct packed {
        logic        done;
        logic [1:0]  sel;
        logic        wr, shift;
        logic        r3, r5, r6, r7, r8, r9, r11, r12;
        logic        e3, e5, e6, e7, e8, e9, e10, e11, e12;
        logic [15:0] en1, en2, en4;
    } outs_t;

    typedef struct {
        logic       start;
        logic [6:0] cout;
        outs_t      exp;
    } vec_t;

    typedef enum {P_IDLE, P_INIT, P_FLT, P_IMG, P_WIN, P_MAC, P_PUSH, P_WR, P_ROW, P_DONE} phase_t;

    localparam logic [6:0] C3 = 7'b1000000, C5 = 7'b0100000, C7 = 7'b0001000,
                           C8 = 7'b0000100, C9 = 7'b0000010;

    int    n_vec = 0;
    int    n_bad = 0;
    vec_t  vecs[$];
    outs_t sb[$];

    function automatic outs_t ex(phase_t p, logic [15:0] e1 = '0, logic [15:0] e2 = '0);
        outs_t o = '0;
        case (p)
            P_INIT: {o.r3, o.r5, o.r6, o.r7, o.r8, o.r9, o.r11, o.r12} = '1;
            P_FLT:  begin o.sel = 2'b01; o.e9 = 1'b1; o.en1 = e1; end
            P_IMG:  begin o.e6 = 1'b1; o.en2 = e2; end
            P_WIN:  begin o.en4 = 16'hFFFF; o.r5 = 1'b1; o.r12 = 1'b1; end
            P_MAC:  begin o.e5 = 1'b1; o.e12 = 1'b1; end
            P_PUSH: begin o.e10 = 1'b1; o.e8 = 1'b1; o.e3 = 1'b1; end
            P_WR:   begin o.sel = 2'b10; o.wr = 1'b1; o.e7 = 1'b1; end
            P_ROW:  begin o.shift = 1'b1; o.e6 = 1'b1; o.en2 = 16'hF000; o.r3 = 1'b1; end
            P_DONE: o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t act();
        outs_t a;
        a.done = f.done; a.sel = f.sel; a.wr = f.wr; a.shift = f.shift;
        {a.r3, a.r5, a.r6, a.r7, a.r8, a.r9, a.r11, a.r12} =
            {f.rst3, f.rst5, f.rst6, f.rst7, f.rst8, f.rst9, f.rst11, f.rst12};
        {a.e3, a.e5, a.e6, a.e7, a.e8, a.e9, a.e10, a.e11, a.e12} =
            {f.en3, f.en5, f.en6, f.en7, f.en8, f.en9, f.en10, f.en11, f.en12};
        a.en1 = f.en1; a.en2 = f.en2; a.en4 = f.en4;
        return a;
    endfunction

    task automatic chk(string nm, int idx);
        outs_t e = sb.pop_front();
        outs_t a = act();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, a, e);
        end
    endtask

    task automatic drive(logic s, logic [6:0] cv);
        f.start = s;
        {f.cout3, f.cout5, f.cout6, f.cout7, f.cout8, f.cout9, f.cout11} = cv;
    endtask

    task automatic add(logic s, logic [6:0] cv, outs_t e);
        vec_t v;
        v.start = s; v.cout = cv; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic pixel(logic [6:0] push_flags, logic s);
        add(s, 7'd0, ex(P_WIN));
        for (int i = 0; i < 15; i++) add(s, 7'd0, ex(P_MAC));
        add(s, C5, ex(P_MAC));
        add(0, push_flags, ex(P_PUSH));
    endtask

    task automatic load_phase();
        logic [15:0] lf[4];
        lf = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
        add(1, 7'd0, ex(P_IDLE));
        add(0, 7'd0, ex(P_INIT));
        for (int i = 0; i < 4; i++) add(0, i == 3 ? C9 : 7'd0, ex(P_FLT, lf[i]));
        for (int i = 0; i < 16; i++) add(0, 7'd0, ex(P_IMG, '0, 16'd1 << i));
    endtask

    task automatic run(string nm);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].cout);
            sb.push_back(vecs[i].exp);
            #1 chk(nm, i);
        end
        vecs.delete();
    endtask

    initial begin
        drive(0, 7'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sb.push_back(ex(P_IDLE));
            #1 chk("reset", i);
        end
        n_vec++;
        if ({f.X, f.Y, f.Z} !== {7'd0, 7'd64, 7'd80}) begin
            n_bad++;
            $display("FAIL bases: got %h want %h", {f.X, f.Y, f.Z}, {7'd0, 7'd64, 7'd80});
        end
        @(negedge clk) rst = 1'b0;

        add(0, 7'd0, ex(P_IDLE));
        load_phase();
        pixel(7'd0, 0);
        pixel(C7, 1);
        pixel(7'd0, 0);
        pixel(C8, 0);
        add(0, 7'd0, ex(P_WR));
        for (int i = 0; i < 3; i++) pixel(7'd0, 0);
        pixel(C8 | C3, 0);
        add(0, C3, ex(P_WR));
        add(0, 7'd0, ex(P_ROW));
        pixel(C3, 0);
        add(0, 7'd0, ex(P_ROW));
        pixel(C8, 0);
        add(0, C7 | C3, ex(P_WR));
        for (int i = 0; i < 3; i++) add(1, 7'd0, ex(P_DONE));
        add(0, 7'd0, ex(P_DONE));
        add(0, 7'd0, ex(P_IDLE));
        add(0, 7'd0, ex(P_IDLE));
        run("pass");

        load_phase();
        add(0, 7'd0, ex(P_WIN));
        for (int i = 0; i < 3; i++) add(0, 7'd0, ex(P_MAC));
        run("pre_abort");
        @(negedge clk);
        drive(0, 7'd0);
        #2 rst = 1'b1;
        sb.push_back(ex(P_IDLE));
        #1 chk("abort", 0);
        @(negedge clk);
        sb.push_back(ex(P_IDLE));
        #1 chk("abort", 1);
        @(negedge clk) rst = 1'b0;
        add(1, 7'd0, ex(P_IDLE));
        add(0, 7'd0, ex(P_INIT));
        add(0, 7'd0, ex(P_FLT, 16'h000F));
        add(0, 7'd0, ex(P_FLT, 16'h00F0));
        run("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
